// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS sequencer: FSM states, CTRL bit
// positions, register indices and the burst-completion rule.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } dds_state_e;

  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_CONTINUOUS = 1;
  localparam int CTRL_PHASE_CLR  = 2;

  localparam int REG_CTRL   = 0;
  localparam int REG_DATA   = 1;
  localparam int REG_CLKDIV = 2;
  localparam int REG_STAT   = 3;
  localparam int REG_LNGTH  = 4;

  // A finite burst is over once the accepted count has reached the length.
  function automatic logic burst_complete(input logic        continuous,
                                          input logic [31:0] count,
                                          input logic [31:0] lngth);
    return (!continuous) && (count >= lngth);
  endfunction

endpackage

// File: rtl/dds_tick_gen.sv
// Sample-rate divider: one tick every div+1 enabled, unfrozen cycles.
module dds_tick_gen
  import dds_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        freeze,
  input  logic [31:0] div,
  output logic        tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Tick decode and next count; a disabled divider always restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    tick  = enable && !freeze && (cnt_q == div);
    if (!enable) begin
      cnt_d = 32'd0;
    end else if (freeze) begin
      cnt_d = cnt_q;
    end else if (tick) begin
      cnt_d = 32'd0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Divider count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dds_sequencer.sv
// DDS burst sequencer: advances a phase accumulator on divided ticks and
// presents each phase/LUT address under a valid/ready handshake.
module dds_sequencer
  import dds_pkg::*;
#(
  parameter int SIG_WIDTH      = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               i_seq_ctrl_reg,
  input  logic [31:0]               i_seq_data_reg,
  input  logic [31:0]               i_seq_clk_div_reg,
  input  logic [31:0]               i_seq_lngth_reg,
  input  logic                      i_seq_ready,
  output logic                      o_seq_valid,
  output logic [LUT_ADDR_WIDTH-1:0] o_seq_lut_addr,
  output logic [PHASE_WIDTH-1:0]    o_seq_phase,
  output logic [31:0]               o_seq_count,
  output logic                      o_seq_busy,
  output logic                      o_seq_done
);

  dds_state_e             state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [31:0]            count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   en_s, cont_s, phase_clr_s;
  logic                   accept_s, freeze_s, tick_en_s, tick_s;
  logic [31:0]            count_acc_s;
  logic                   unused_ok;

  assign en_s        = i_seq_ctrl_reg[CTRL_ENABLE];
  assign cont_s      = i_seq_ctrl_reg[CTRL_CONTINUOUS];
  assign phase_clr_s = i_seq_ctrl_reg[CTRL_PHASE_CLR];
  assign unused_ok   = ^{i_seq_ctrl_reg[31:3], 1'(SIG_WIDTH > 0)};

  assign accept_s    = valid_q && i_seq_ready;
  // A presented but unaccepted sample must not be overwritten by a new tick.
  assign freeze_s    = valid_q && !i_seq_ready;
  assign tick_en_s   = (state_q == RUN) || (state_q == HOLD);
  assign count_acc_s = count_q + {31'd0, accept_s};

  dds_tick_gen u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (tick_en_s),
    .freeze (freeze_s),
    .div    (i_seq_clk_div_reg),
    .tick   (tick_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (phase_clr_s) begin
          phase_d = '0;
        end else begin
          phase_d = phase_q;
        end
        if (en_s) begin
          state_d = RUN;
          count_d = 32'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN, HOLD: begin
        count_d = count_acc_s;
        if (freeze_s) begin
          state_d = HOLD;
        end else if (!en_s) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (burst_complete(cont_s, count_acc_s, i_seq_lngth_reg)) begin
          state_d = DONE;
          valid_d = 1'b0;
        end else begin
          state_d = RUN;
          if (tick_s) begin
            valid_d = 1'b1;
            phase_d = phase_q + i_seq_data_reg[PHASE_WIDTH-1:0];
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        if (!en_s) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == HOLD);
    done_d = (state_d == DONE);
  end

  // State, datapath and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      count_q <= 32'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_seq_valid    = valid_q;
  assign o_seq_lut_addr = phase_q[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
  assign o_seq_phase    = phase_q;
  assign o_seq_count    = count_q;
  assign o_seq_busy     = busy_q;
  assign o_seq_done     = done_q;

endmodule

// File: tb/tb_dds_sequencer.sv
// Directed bench for dds_sequencer: cycle table plus hand-written burst,
// backpressure, enable-drop and reset sequences.
module tb_dds_sequencer;
  import dds_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ctrl, data, div, lngth;
  logic        ready;
  logic        o_seq_valid;
  logic [9:0]  o_seq_lut_addr;
  logic [31:0] o_seq_phase;
  logic [31:0] o_seq_count;
  logic        o_seq_busy;
  logic        o_seq_done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  dds_sequencer #(.SIG_WIDTH(16), .PHASE_WIDTH(32), .LUT_ADDR_WIDTH(10)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_seq_ctrl_reg    (ctrl),
    .i_seq_data_reg    (data),
    .i_seq_clk_div_reg (div),
    .i_seq_lngth_reg   (lngth),
    .i_seq_ready       (ready),
    .o_seq_valid       (o_seq_valid),
    .o_seq_lut_addr    (o_seq_lut_addr),
    .o_seq_phase       (o_seq_phase),
    .o_seq_count       (o_seq_count),
    .o_seq_busy        (o_seq_busy),
    .o_seq_done        (o_seq_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] ctrl, data, div, lngth;
    logic        ready;
    logic        valid;
    logic [9:0]  addr;
    logic [31:0] phase, count;
    logic        busy, done;
  } vec_t;

  vec_t tbl[13];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_valid(input int max_cyc, input string name);
    int i;
    i = 0;
    while (!o_seq_valid && i < max_cyc) begin
      step();
      i++;
    end
    chk(name, 32'(o_seq_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int          t0, last, nsamp;
    logic [31:0] inc, exp_ph;

    //          rst   ctrl    data          div    lngth  rdy   valid addr    phase         count  busy  done
    tbl[0]  = '{1'b1, 32'h0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h000, 32'h0000_0000, 32'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h3, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h000, 32'h0000_0000, 32'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 32'h3, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b1, 10'h200, 32'h8000_0000, 32'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 32'h3, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b1, 10'h000, 32'h0000_0000, 32'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 32'h3, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b1, 10'h200, 32'h8000_0000, 32'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h3, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b1, 10'h200, 32'h8000_0000, 32'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 32'h3, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b1, 10'h200, 32'h8000_0000, 32'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h200, 32'h8000_0000, 32'd3, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h4, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h000, 32'h0000_0000, 32'd3, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h1, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h000, 32'h0000_0000, 32'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'h1, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h000, 32'h0000_0000, 32'd0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 32'h1, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h000, 32'h0000_0000, 32'd0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 32'h0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0, 10'h000, 32'h0000_0000, 32'd0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst   = tbl[i].rst;
      ctrl  = tbl[i].ctrl;
      data  = tbl[i].data;
      div   = tbl[i].div;
      lngth = tbl[i].lngth;
      ready = tbl[i].ready;
      step();
      chk($sformatf("v%0d_valid", i), 32'(o_seq_valid), 32'(tbl[i].valid));
      chk($sformatf("v%0d_addr", i), 32'(o_seq_lut_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_phase", i), o_seq_phase, tbl[i].phase);
      chk($sformatf("v%0d_count", i), o_seq_count, tbl[i].count);
      chk($sformatf("v%0d_busy", i), 32'(o_seq_busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(o_seq_done), 32'(tbl[i].done));
    end

    // Finite burst: div 3, four samples spaced four cycles apart.
    inc   = 32'h1000_0000;
    div   = 32'd3;
    data  = inc;
    lngth = 32'd4;
    ready = 1'b1;
    ctrl  = 32'h4;
    step();
    ctrl  = 32'h1;
    step();
    chk("burst_busy", 32'(o_seq_busy), 32'd1);
    t0    = cyc;
    last  = t0;
    nsamp = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_seq_valid) begin
        nsamp++;
        exp_ph = inc * 32'(nsamp);
        chk("burst_gap", 32'(cyc - last), 32'd4);
        chk("burst_phase", o_seq_phase, exp_ph);
        chk("burst_addr", 32'(o_seq_lut_addr), exp_ph >> 22);
        last = cyc;
      end
      if (o_seq_done) break;
    end
    chk("burst_done", 32'(o_seq_done), 32'd1);
    chk("burst_nsamp", 32'(nsamp), 32'd4);
    chk("burst_count", o_seq_count, 32'd4);
    chk("burst_valid_drop", 32'(o_seq_valid), 32'd0);
    step();
    chk("done_hold", 32'(o_seq_done), 32'd1);
    chk("done_phase", o_seq_phase, 32'h4000_0000);
    ctrl = 32'h0;
    step();
    chk("done_exit", 32'(o_seq_done), 32'd0);

    // Backpressure: hold the second sample for 10 cycles.
    inc   = 32'h0123_4567;
    data  = inc;
    div   = 32'd2;
    lngth = 32'd10;
    ctrl  = 32'h4;
    step();
    ctrl  = 32'h1;
    step();
    wait_valid(10, "bp_first_valid");
    chk("bp_first_phase", o_seq_phase, inc);
    step();
    chk("bp_after_accept", 32'(o_seq_valid), 32'd0);
    wait_valid(10, "bp_second_valid");
    exp_ph = inc * 32'd2;
    chk("bp_second_phase", o_seq_phase, exp_ph);
    chk("bp_second_count", o_seq_count, 32'd1);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", 32'(o_seq_valid), 32'd1);
      chk("hold_phase", o_seq_phase, exp_ph);
      chk("hold_addr", 32'(o_seq_lut_addr), exp_ph >> 22);
      chk("hold_count", o_seq_count, 32'd1);
      chk("hold_state", 32'(dut.state_q), 32'(HOLD));
    end
    ready = 1'b1;
    step();
    chk("release_valid", 32'(o_seq_valid), 32'd0);
    chk("release_count", o_seq_count, 32'd2);
    step();
    chk("release_wait", 32'(o_seq_valid), 32'd0);
    step();
    chk("release_tick", 32'(o_seq_valid), 32'd1);
    chk("release_phase", o_seq_phase, inc * 32'd3);

    // ENABLE dropped with a sample pending: handshake completes, then IDLE.
    ctrl  = 32'h0;
    ready = 1'b0;
    step();
    chk("endrop_valid", 32'(o_seq_valid), 32'd1);
    chk("endrop_busy", 32'(o_seq_busy), 32'd1);
    chk("endrop_phase", o_seq_phase, inc * 32'd3);
    step();
    chk("endrop_valid2", 32'(o_seq_valid), 32'd1);
    ready = 1'b1;
    step();
    chk("endrop_idle_valid", 32'(o_seq_valid), 32'd0);
    chk("endrop_idle_busy", 32'(o_seq_busy), 32'd0);
    chk("endrop_count", o_seq_count, 32'd3);

    // Reset mid-burst with a handshake pending.
    div   = 32'd0;
    ready = 1'b0;
    ctrl  = 32'h1;
    step();
    wait_valid(5, "rst_pending_valid");
    rst = 1'b1;
    step();
    chk("rst_valid", 32'(o_seq_valid), 32'd0);
    chk("rst_busy", 32'(o_seq_busy), 32'd0);
    chk("rst_done", 32'(o_seq_done), 32'd0);
    chk("rst_phase", o_seq_phase, 32'd0);
    chk("rst_count", o_seq_count, 32'd0);
    rst  = 1'b0;
    ctrl = 32'h0;
    step();
    chk("post_rst_valid", 32'(o_seq_valid), 32'd0);
    chk("post_rst_busy", 32'(o_seq_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dds_sequencer.md
DDS_SEQUENCER -- requirements
Module: dds_sequencer

Interface
REQ-001 Parameter SIG_WIDTH, default 16, sample width of the DDS datapath.
REQ-002 Parameter PHASE_WIDTH, default 32, phase accumulator width.
REQ-003 Parameter LUT_ADDR_WIDTH, default 10, waveform LUT address width.
REQ-004 Port clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 Port rst  in  1  reset, synchronous and active-high.
REQ-006 Port i_seq_ctrl_reg  in  32  CTRL register: bit0 ENABLE, bit1 CONTINUOUS, bit2 PHASE_CLR, others ignored.
REQ-007 Port i_seq_data_reg  in  32  phase increment, low PHASE_WIDTH bits used.
REQ-008 Port i_seq_clk_div_reg  in  32  tick divider; one tick every clk_div+1 cycles.
REQ-009 Port i_seq_lngth_reg  in  32  burst length in samples.
REQ-010 Port i_seq_ready  in  1  downstream sample ready.
REQ-011 Port o_seq_valid  out  1  sample valid; the LUT address is valid with it.
REQ-012 Port o_seq_lut_addr  out  LUT_ADDR_WIDTH  phase[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH].
REQ-013 Port o_seq_phase  out  PHASE_WIDTH  current accumulator value.
REQ-014 Port o_seq_count  out  32  accepted samples in the current burst.
REQ-015 Port o_seq_busy  out  1  high in RUN and HOLD.
REQ-016 Port o_seq_done  out  1  high in DONE.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN, HOLD and DONE.
REQ-018 IDLE: when ENABLE=1, go to RUN next cycle, clearing count and the tick counter. PHASE_CLR=1 SHALL zero the phase each IDLE cycle.
REQ-019 RUN: the tick counter increments each cycle. A tick occurs when counter==clk_div, and the counter then returns to 0. clk_div=0 gives a tick every cycle.
REQ-020 On a tick, phase <= phase + data_reg (modulo 2^PHASE_WIDTH, wrap silently) and o_seq_valid <= 1. The increment is sampled at the tick, so live frequency changes are allowed.
REQ-021 First valid: entering RUN at cycle T SHALL give o_seq_valid=1 at cycle T+clk_div+1.
REQ-022 Handshake: a sample is accepted when valid&&ready. Valid SHALL stay high with a stable phase and address until it is accepted. valid&&!ready SHALL move the FSM to HOLD and freeze the tick counter.
REQ-023 HOLD: on ready, the sample is accepted, then the FSM returns to RUN or goes to DONE.
REQ-024 Each acceptance SHALL increment count.
REQ-025 When CONTINUOUS=0 and the accepted count reaches lngth, the FSM SHALL go to DONE and valid SHALL drop the next cycle.
REQ-026 When CONTINUOUS=1, lngth is ignored and count wraps 2^32-1 -> 0.
REQ-027 lngth=0 with CONTINUOUS=0 SHALL go RUN -> DONE after one cycle with no sample emitted.
REQ-028 If ENABLE drops in RUN with no valid pending, the FSM SHALL go to IDLE next cycle.
REQ-029 If ENABLE drops with valid pending (RUN or HOLD), the sample SHALL complete its handshake before the FSM goes to IDLE.
REQ-030 DONE: hold phase and count. Return to IDLE only when ENABLE=0; a new burst requires an ENABLE 0->1 transition.
REQ-031 A tick and an acceptance in the same cycle SHALL both take effect: the new sample is presented and count increments.
REQ-032 PHASE_CLR SHALL be ignored in RUN, HOLD and DONE.

Reset
REQ-033 While rst=1 at a clock edge: state=IDLE, and phase, count, tick counter, valid, busy and done SHALL all be 0.
REQ-034 A reset mid-burst SHALL abort with no further valid, even if a handshake is pending.

Structure
REQ-035 Package dds_pkg SHALL hold the state enum, the CTRL bit positions (ENABLE=0, CONTINUOUS=1, PHASE_CLR=2) and the register indices (CTRL=0, DATA=1, CLKDIV=2, STAT=3, LNGTH=4).
REQ-036 The tick counter SHALL be the sub-module dds_tick_gen, with inputs enable, freeze and div, and output tick.

Verification
REQ-037 Scenario: clk_div=3, data=0x1000_0000, lngth=4, ready=1, ENABLE 0->1 -> valid pulses every 4 cycles, phases 0x1000_0000..0x4000_0000, done=1, count=4.
REQ-038 Scenario: clk_div=0, data=0x8000_0000, CONTINUOUS=1, ready=1 -> valid high every cycle, phase alternates 0x8000_0000/0x0, lut_addr alternates 0x200/0x000.
REQ-039 Scenario: ready=0 for 10 cycles mid-burst -> valid and address stable, state HOLD, no count change, no tick counter advance.
REQ-040 Scenario: lngth=0, CONTINUOUS=0, ENABLE=1 -> DONE with no valid. Then ENABLE=0 and PHASE_CLR=1 -> IDLE, phase=0.
REQ-041 Scenario: ENABLE dropped while in HOLD -> valid held until ready, then IDLE. A separate rst pulse mid-burst -> all outputs 0 the next cycle.
